// File: rtl/machine_csr_pkg.sv
// Shared definitions for the machine-mode CSR file.
// Holds the CSR address map, mstatus/mie/mip bit positions, the Zicsr
// operation encoding (funct3[1:0]) and the mtvec MODE encodings.
package machine_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MSIP     = 3;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam int CNT_W = 64;

    // funct3[1:0]; funct3[2] only selects the immediate source
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'b00,
        MTVEC_VECTORED = 2'b01
    } mtvec_mode_e;

endpackage

// File: rtl/machine_csr_file_counter64.sv
// 64-bit performance counter (mcycle / minstret).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   inc_i              advance by one this cycle
//   wr_lo_i, wr_hi_i   software write of low / high 32-bit half
//   wdata_i            software write data
//   count_o            current 64-bit count
module csr_counter64
    import machine_csr_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // A software write to either half replaces this cycle's increment
    // for the whole counter; the unwritten half holds.
    always_comb begin
        count_d = count_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) count_d[31:0]  = wdata_i;
            if (wr_hi_i) count_d[63:32] = wdata_i;
        end else if (inc_i) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/machine_csr_file.sv
// Machine-mode CSR register file, responder to the trap controller.
// Executes Zicsr RW/RS/RC(I) from execute, applies trap strobes to
// mstatus/mepc/mcause/mtval, owns mcycle/minstret and samples irq lines.
// Ports:
//   clk_in, rst_n_in                 clock, asynchronous active-low reset
//   csr_addr_in/wr_en_in/op_in       CSR instruction (address, valid, funct3)
//   rs1_data_in, zimm_in             register / immediate source
//   csr_data_out, illegal_csr_out    old CSR value (combinational), illegal flag
//   set_epc_in ... misaligned_addr_in trap strobes and trap information
//   instruct_inc_in                  instruction retired (minstret)
//   eirq_in, tirq_in, sirq_in        raw interrupt lines
//   mie_out ... msip_out             enable / pending bits to controller
//   trap_address_out, epc_out        trap target PC, mepc
module machine_csr_file
    import machine_csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0,
    parameter logic [XLEN-1:0] MHARTID     = '0
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [11:0]     csr_addr_in,
    input  logic            csr_wr_en_in,
    input  logic [2:0]      csr_op_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [4:0]      zimm_in,
    output logic [XLEN-1:0] csr_data_out,
    output logic            illegal_csr_out,
    input  logic            set_epc_in,
    input  logic            set_cause_in,
    input  logic            mie_clear_in,
    input  logic            mie_set_in,
    input  logic            i_or_e_in,
    input  logic [3:0]      cause_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            misaligned_exception_in,
    input  logic [XLEN-1:0] misaligned_addr_in,
    input  logic            instruct_inc_in,
    input  logic            eirq_in,
    input  logic            tirq_in,
    input  logic            sirq_in,
    output logic            mie_out,
    output logic            meie_out,
    output logic            mtie_out,
    output logic            msie_out,
    output logic            meip_out,
    output logic            mtip_out,
    output logic            msip_out,
    output logic [XLEN-1:0] trap_address_out,
    output logic [XLEN-1:0] epc_out
);

    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic            meie_q, meie_d, mtie_q, mtie_d, msie_q, msie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mtval_q, mtval_d;
    logic            mcause_int_q, mcause_int_d;
    logic [3:0]      mcause_code_q, mcause_code_d;
    logic            meip_q, mtip_q, msip_q;

    logic [CNT_W-1:0] mcycle, minstret;

    logic [XLEN-1:0] mstatus_val, mie_val, mip_val, mcause_val;
    logic [XLEN-1:0] src, rdata, wdata, mtvec_base;
    logic            known, read_only, do_write, we;
    csr_op_e         op;

    assign mstatus_val = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};
    assign mie_val     = {{(XLEN-12){1'b0}}, meie_q, 3'b000, mtie_q, 3'b000, msie_q, 3'b000};
    assign mip_val     = {{(XLEN-12){1'b0}}, meip_q, 3'b000, mtip_q, 3'b000, msip_q, 3'b000};
    assign mcause_val  = {mcause_int_q, {(XLEN-5){1'b0}}, mcause_code_q};

    assign op  = csr_op_e'(csr_op_in[1:0]);
    assign src = csr_op_in[2] ? {{(XLEN-5){1'b0}}, zimm_in} : rs1_data_in;

    always_comb begin
        rdata     = '0;
        known     = 1'b1;
        read_only = 1'b0;
        case (csr_addr_in)
            CSR_MSTATUS:   rdata = mstatus_val;
            CSR_MISA:      begin rdata = MISA_VALUE; read_only = 1'b1; end
            CSR_MIE:       rdata = mie_val;
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_val;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       begin rdata = mip_val; read_only = 1'b1; end
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: read_only = 1'b1;
            CSR_MHARTID:   begin rdata = MHARTID; read_only = 1'b1; end
            default:       known = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            CSR_OP_RW: wdata = src;
            CSR_OP_RS: wdata = rdata | src;
            CSR_OP_RC: wdata = rdata & ~src;
            default:   wdata = rdata;
        endcase
    end

    // RS/RC with a zero source are pure reads: no write, so RO is fine.
    assign do_write = csr_wr_en_in && known &&
                      ((op == CSR_OP_RW) ||
                       (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (src != '0)));
    assign we              = do_write && !read_only;
    assign illegal_csr_out = csr_wr_en_in && (!known || (do_write && read_only));
    assign csr_data_out    = rdata;

    always_comb begin
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        meie_d        = meie_q;
        mtie_d        = mtie_q;
        msie_d        = msie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_int_d  = mcause_int_q;
        mcause_code_d = mcause_code_q;
        mtval_d       = mtval_q;
        if (we) begin
            case (csr_addr_in)
                CSR_MSTATUS: begin
                    mie_d  = wdata[MSTATUS_MIE];
                    mpie_d = wdata[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    meie_d = wdata[MIE_MEIE];
                    mtie_d = wdata[MIE_MTIE];
                    msie_d = wdata[MIE_MSIE];
                end
                CSR_MTVEC: begin
                    // reserved MODE values (1x) leave the old MODE in place
                    mtvec_d[XLEN-1:2] = wdata[XLEN-1:2];
                    if (!wdata[1]) mtvec_d[1:0] = wdata[1:0];
                end
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d     = {wdata[XLEN-1:2], 2'b00};
                CSR_MCAUSE: begin
                    mcause_int_d  = wdata[XLEN-1];
                    mcause_code_d = wdata[3:0];
                end
                CSR_MTVAL:    mtval_d    = wdata;
                default: ;
            endcase
        end
        // Trap strobes are applied last so they win over a same-cycle write.
        if (set_epc_in) mepc_d = {pc_in[XLEN-1:2], 2'b00};
        if (set_cause_in) begin
            mcause_int_d  = i_or_e_in;
            mcause_code_d = cause_in;
            mtval_d       = misaligned_exception_in ? misaligned_addr_in : '0;
        end
        if (mie_clear_in) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (mie_set_in) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            meie_q        <= 1'b0;
            mtie_q        <= 1'b0;
            msie_q        <= 1'b0;
            mtvec_q       <= RESET_MTVEC;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_int_q  <= 1'b0;
            mcause_code_q <= '0;
            mtval_q       <= '0;
            meip_q        <= 1'b0;
            mtip_q        <= 1'b0;
            msip_q        <= 1'b0;
        end else begin
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            meie_q        <= meie_d;
            mtie_q        <= mtie_d;
            msie_q        <= msie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_int_q  <= mcause_int_d;
            mcause_code_q <= mcause_code_d;
            mtval_q       <= mtval_d;
            meip_q        <= eirq_in;
            mtip_q        <= tirq_in;
            msip_q        <= sirq_in;
        end
    end

    csr_counter64 u_mcycle (
        .clk_i   (clk_in),
        .rst_ni  (rst_n_in),
        .inc_i   (1'b1),
        .wr_lo_i (we && (csr_addr_in == CSR_MCYCLE)),
        .wr_hi_i (we && (csr_addr_in == CSR_MCYCLEH)),
        .wdata_i (wdata),
        .count_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_in),
        .rst_ni  (rst_n_in),
        .inc_i   (instruct_inc_in),
        .wr_lo_i (we && (csr_addr_in == CSR_MINSTRET)),
        .wr_hi_i (we && (csr_addr_in == CSR_MINSTRETH)),
        .wdata_i (wdata),
        .count_o (minstret)
    );

    // Vectored mode offsets only interrupts; exceptions go to the base.
    assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_address_out =
        ((mtvec_q[1:0] == MTVEC_VECTORED) && mcause_int_q)
            ? mtvec_base + {{(XLEN-6){1'b0}}, mcause_code_q, 2'b00}
            : mtvec_base;

    assign epc_out  = mepc_q;
    assign mie_out  = mie_q;
    assign meie_out = meie_q;
    assign mtie_out = mtie_q;
    assign msie_out = msie_q;
    assign meip_out = meip_q;
    assign mtip_out = mtip_q;
    assign msip_out = msip_q;

endmodule

// File: tb/tb_machine_csr_file.sv
module tb_machine_csr_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic        csr_wr_en;
    logic [2:0]  csr_op;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic [31:0] csr_data;
    logic        illegal;
    logic        set_epc, set_cause, mie_clear, mie_set, i_or_e;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic        mis_exc;
    logic [31:0] mis_addr;
    logic        instr_inc;
    logic        eirq, tirq, sirq;
    logic        mie_o, meie_o, mtie_o, msie_o, meip_o, mtip_o, msip_o;
    logic [31:0] trap_addr, epc;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] saved;

    localparam logic [2:0] OP_RW = 3'b001, OP_RS = 3'b010, OP_RC = 3'b011, OP_RSI = 3'b110;

    always #5 clk = ~clk;

    machine_csr_file #(
        .XLEN        (32),
        .RESET_MTVEC (32'h0000_1001),
        .MHARTID     (32'd3)
    ) dut (
        .clk_in                  (clk),
        .rst_n_in                (rst_n),
        .csr_addr_in             (csr_addr),
        .csr_wr_en_in            (csr_wr_en),
        .csr_op_in               (csr_op),
        .rs1_data_in             (rs1_data),
        .zimm_in                 (zimm),
        .csr_data_out            (csr_data),
        .illegal_csr_out         (illegal),
        .set_epc_in              (set_epc),
        .set_cause_in            (set_cause),
        .mie_clear_in            (mie_clear),
        .mie_set_in              (mie_set),
        .i_or_e_in               (i_or_e),
        .cause_in                (cause),
        .pc_in                   (pc),
        .misaligned_exception_in (mis_exc),
        .misaligned_addr_in      (mis_addr),
        .instruct_inc_in         (instr_inc),
        .eirq_in                 (eirq),
        .tirq_in                 (tirq),
        .sirq_in                 (sirq),
        .mie_out                 (mie_o),
        .meie_out                (meie_o),
        .mtie_out                (mtie_o),
        .msie_out                (msie_o),
        .meip_out                (meip_o),
        .mtip_out                (mtip_o),
        .msip_out                (msip_o),
        .trap_address_out        (trap_addr),
        .epc_out                 (epc)
    );

    task automatic issue(input logic [11:0] a, input logic [2:0] op,
                         input logic [31:0] d, input logic [4:0] z);
        csr_addr = a; csr_op = op; rs1_data = d; zimm = z; csr_wr_en = 1'b1;
        #1;
    endtask

    // Advance past the next rising edge and drop all single-cycle pulses.
    task automatic commit();
        @(posedge clk);
        #1;
        csr_wr_en = 1'b0; set_epc = 1'b0; set_cause = 1'b0;
        mie_clear = 1'b0; mie_set = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a);
        csr_addr = a;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; csr_addr = 12'h000; csr_wr_en = 1'b0; csr_op = 3'b000;
        rs1_data = '0; zimm = '0; set_epc = 0; set_cause = 0; mie_clear = 0;
        mie_set = 0; i_or_e = 0; cause = '0; pc = '0; mis_exc = 0; mis_addr = '0;
        instr_inc = 0; eirq = 0; tirq = 0; sirq = 0;
        #12;
        rd(12'h305);
        vectors++; if (csr_data !== 32'h0000_1001) begin errors++; $display("FAIL reset_mtvec got %h exp %h", csr_data, 32'h0000_1001); end
        rd(12'h300);
        vectors++; if (csr_data !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus got %h exp %h", csr_data, 32'h0000_1800); end
        vectors++; if (trap_addr !== 32'h0000_1000) begin errors++; $display("FAIL reset_trap_addr got %h exp %h", trap_addr, 32'h0000_1000); end
        vectors++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp 0", epc); end
        vectors++;
        if ({mie_o, meie_o, mtie_o, msie_o, meip_o, mtip_o, msip_o, illegal} !== 8'h00) begin
            errors++;
            $display("FAIL reset_bits got %b exp 00000000", {mie_o, meie_o, mtie_o, msie_o, meip_o, mtip_o, msip_o, illegal});
        end
        rst_n = 1'b1;
        commit();
    endtask

    task automatic test_enables();
        issue(12'h304, OP_RW, 32'h888, 5'd0);
        commit();
        rd(12'h304);
        vectors++; if (csr_data !== 32'h888) begin errors++; $display("FAIL mie_rw got %h exp 888", csr_data); end
        issue(12'h300, OP_RS, 32'h8, 5'd0);
        commit();
        vectors++; if ({mie_o, meie_o, mtie_o, msie_o} !== 4'b1111) begin errors++; $display("FAIL enables got %b exp 1111", {mie_o, meie_o, mtie_o, msie_o}); end
        rd(12'h300);
        vectors++; if (csr_data !== 32'h0000_1808) begin errors++; $display("FAIL mstatus_rs got %h exp 00001808", csr_data); end
        issue(12'h304, OP_RC, 32'h80, 5'd0);
        commit();
        vectors++; if ({meie_o, mtie_o, msie_o} !== 3'b101) begin errors++; $display("FAIL mie_rc got %b exp 101", {meie_o, mtie_o, msie_o}); end
    endtask

    task automatic test_trap();
        // software write to mepc in the same cycle must lose to set_epc
        issue(12'h341, OP_RW, 32'hDEAD_0000, 5'd0);
        set_epc = 1; set_cause = 1; pc = 32'h0000_0103; cause = 4'd4;
        i_or_e = 0; mis_exc = 1; mis_addr = 32'h0000_1235;
        commit();
        vectors++; if (epc !== 32'h0000_0100) begin errors++; $display("FAIL epc got %h exp 00000100", epc); end
        rd(12'h342);
        vectors++; if (csr_data !== 32'h0000_0004) begin errors++; $display("FAIL mcause got %h exp 00000004", csr_data); end
        rd(12'h343);
        vectors++; if (csr_data !== 32'h0000_1235) begin errors++; $display("FAIL mtval got %h exp 00001235", csr_data); end
        mie_clear = 1;
        commit();
        rd(12'h300);
        vectors++; if (mie_o !== 1'b0 || csr_data !== 32'h0000_1880) begin errors++; $display("FAIL mie_clear got mie=%b mstatus=%h exp 0 00001880", mie_o, csr_data); end
        mie_set = 1;
        commit();
        rd(12'h300);
        vectors++; if (mie_o !== 1'b1 || csr_data !== 32'h0000_1888) begin errors++; $display("FAIL mie_set got mie=%b mstatus=%h exp 1 00001888", mie_o, csr_data); end
        mie_clear = 1; mie_set = 1;
        commit();
        rd(12'h300);
        vectors++; if (csr_data !== 32'h0000_1880) begin errors++; $display("FAIL both_strobes got %h exp 00001880", csr_data); end
        mie_set = 1;
        commit();
        issue(12'h300, OP_RW, 32'h0000_0008, 5'd0);
        mie_clear = 1;
        commit();
        rd(12'h300);
        vectors++; if (csr_data !== 32'h0000_1880) begin errors++; $display("FAIL strobe_over_write got %h exp 00001880", csr_data); end
        mie_set = 1;
        commit();
    endtask

    task automatic test_mtvec();
        issue(12'h305, OP_RW, 32'h8000_0101, 5'd0);
        commit();
        rd(12'h305);
        vectors++; if (csr_data !== 32'h8000_0101) begin errors++; $display("FAIL mtvec_rd got %h exp 80000101", csr_data); end
        vectors++; if (trap_addr !== 32'h8000_0100) begin errors++; $display("FAIL trap_exc got %h exp 80000100", trap_addr); end
        set_cause = 1; i_or_e = 1; cause = 4'd11; mis_exc = 0;
        commit();
        vectors++; if (trap_addr !== 32'h8000_012C) begin errors++; $display("FAIL trap_vec got %h exp 8000012c", trap_addr); end
        rd(12'h342);
        vectors++; if (csr_data !== 32'h8000_000B) begin errors++; $display("FAIL mcause_int got %h exp 8000000b", csr_data); end
        rd(12'h343);
        vectors++; if (csr_data !== 32'h0) begin errors++; $display("FAIL mtval_clr got %h exp 0", csr_data); end
        issue(12'h305, OP_RW, 32'h8000_0202, 5'd0);
        commit();
        rd(12'h305);
        vectors++; if (csr_data !== 32'h8000_0201) begin errors++; $display("FAIL mtvec_mode_keep got %h exp 80000201", csr_data); end
        vectors++; if (trap_addr !== 32'h8000_022C) begin errors++; $display("FAIL trap_vec2 got %h exp 8000022c", trap_addr); end
        issue(12'h305, OP_RW, 32'h8000_0300, 5'd0);
        commit();
        vectors++; if (trap_addr !== 32'h8000_0300) begin errors++; $display("FAIL trap_direct got %h exp 80000300", trap_addr); end
    endtask

    task automatic test_counters();
        issue(12'hB00, OP_RW, 32'hFFFF_FFFF, 5'd0);
        commit();
        issue(12'hB80, OP_RW, 32'hFFFF_FFFF, 5'd0);
        commit();
        rd(12'hB00);
        vectors++; if (csr_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_lo_ones got %h exp ffffffff", csr_data); end
        rd(12'hB80);
        vectors++; if (csr_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_hi_ones got %h exp ffffffff", csr_data); end
        commit();
        rd(12'hB00);
        vectors++; if (csr_data !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_lo got %h exp 0", csr_data); end
        rd(12'hB80);
        vectors++; if (csr_data !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_hi got %h exp 0", csr_data); end
        rd(12'hB02);
        vectors++; if (csr_data !== 32'h0) begin errors++; $display("FAIL minstret_idle got %h exp 0", csr_data); end
        instr_inc = 1;
        commit(); commit(); commit();
        instr_inc = 0;
        commit();
        rd(12'hB02);
        vectors++; if (csr_data !== 32'd3) begin errors++; $display("FAIL minstret_inc got %0d exp 3", csr_data); end
        instr_inc = 1;
        issue(12'hB02, OP_RW, 32'h10, 5'd0);
        commit();
        instr_inc = 0;
        rd(12'hB02);
        vectors++; if (csr_data !== 32'h10) begin errors++; $display("FAIL minstret_wr got %h exp 10", csr_data); end
        rd(12'hB82);
        vectors++; if (csr_data !== 32'h0) begin errors++; $display("FAIL minstret_hi got %h exp 0", csr_data); end
    endtask

    task automatic test_illegal();
        issue(12'h340, OP_RW, 32'h0000_A5A5, 5'd0);
        vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL mscratch_legal got %b exp 0", illegal); end
        commit();
        issue(12'hF14, OP_RW, 32'h5, 5'd0);
        vectors++; if (illegal !== 1'b1) begin errors++; $display("FAIL ro_write got %b exp 1", illegal); end
        commit();
        rd(12'hF14);
        vectors++; if (csr_data !== 32'd3) begin errors++; $display("FAIL hartid_kept got %h exp 3", csr_data); end
        issue(12'h7C0, OP_RW, 32'h1, 5'd0);
        vectors++; if (illegal !== 1'b1) begin errors++; $display("FAIL unknown_addr got %b exp 1", illegal); end
        commit();
        rd(12'h340);
        vectors++; if (csr_data !== 32'h0000_A5A5) begin errors++; $display("FAIL mscratch_rd got %h exp 0000a5a5", csr_data); end
        issue(12'hF14, OP_RSI, 32'hFFFF_FFFF, 5'd0);
        vectors++; if (illegal !== 1'b0 || csr_data !== 32'd3) begin errors++; $display("FAIL rsi_zero got ill=%b data=%h exp 0 00000003", illegal, csr_data); end
        commit();
        issue(12'h301, OP_RS, 32'h1, 5'd0);
        vectors++; if (illegal !== 1'b1) begin errors++; $display("FAIL misa_rs got %b exp 1", illegal); end
        commit();
        rd(12'h301);
        vectors++; if (csr_data !== 32'h4000_0100) begin errors++; $display("FAIL misa_rd got %h exp 40000100", csr_data); end
    endtask

    task automatic test_irq();
        eirq = 1; tirq = 0; sirq = 1;
        #1;
        vectors++; if ({meip_o, mtip_o, msip_o} !== 3'b000) begin errors++; $display("FAIL irq_early got %b exp 000", {meip_o, mtip_o, msip_o}); end
        commit();
        vectors++; if ({meip_o, mtip_o, msip_o} !== 3'b101) begin errors++; $display("FAIL irq_pend got %b exp 101", {meip_o, mtip_o, msip_o}); end
        rd(12'h344);
        vectors++; if (csr_data !== 32'h0000_0808) begin errors++; $display("FAIL mip_rd got %h exp 00000808", csr_data); end
        eirq = 0; tirq = 1; sirq = 0;
        commit();
        vectors++; if ({meip_o, mtip_o, msip_o} !== 3'b010) begin errors++; $display("FAIL irq_pend2 got %b exp 010", {meip_o, mtip_o, msip_o}); end
        tirq = 0;
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if ({mie_o, meie_o, msie_o, mtip_o} !== 4'b0000 || epc !== 32'h0) begin errors++; $display("FAIL async_bits got %b epc=%h exp 0000 0", {mie_o, meie_o, msie_o, mtip_o}, epc); end
        rd(12'h305);
        vectors++; if (csr_data !== 32'h0000_1001) begin errors++; $display("FAIL async_mtvec got %h exp 00001001", csr_data); end
        rd(12'hB00);
        vectors++; if (csr_data !== 32'h0) begin errors++; $display("FAIL async_mcycle got %h exp 0", csr_data); end
        rd(12'h340);
        vectors++; if (csr_data !== 32'h0) begin errors++; $display("FAIL async_mscratch got %h exp 0", csr_data); end
        commit();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_enables();
        test_trap();
        test_mtvec();
        test_counters();
        test_illegal();
        test_irq();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
